// File: rtl/i2c_cfg_pkg.sv
// Shared types and default constants for the I2C configuration sequencer.
package i2c_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE,
    GAP,
    DONE,
    FAIL
  } seq_state_t;

  typedef struct packed {
    logic [7:0] reg_addr;
    logic [7:0] data;
  } cfg_entry_t;

  localparam int         DEF_NUM_WRITES     = 10;
  localparam logic [6:0] DEF_SLAVE_ADDR     = 7'h1A;
  localparam int         DEF_MAX_RETRIES    = 3;
  localparam int         DEF_GAP_CYCLES     = 4;
  localparam int         DEF_TIMEOUT_CYCLES = 64;

  // Width needed to hold 0..max_val, never less than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/i2c_config_sequencer_rom.sv
// Combinational register table for the codec bring-up sequence.
module config_rom
  import i2c_cfg_pkg::*;
#(
  parameter int NUM_WRITES = DEF_NUM_WRITES,
  parameter int IDX_W      = cnt_width(NUM_WRITES)
) (
  input  logic [IDX_W-1:0] index,
  output cfg_entry_t       entry
);

  // Look up the entry; indices past the table return an all-zero write.
  always_comb begin
    entry = '0;
    if (int'(index) < NUM_WRITES) begin
      case (int'(index))
        0:       entry = {8'h0F, 8'h00};
        1:       entry = {8'h06, 8'h10};
        2:       entry = {8'h07, 8'h42};
        3:       entry = {8'h08, 8'h00};
        4:       entry = {8'h00, 8'h17};
        5:       entry = {8'h01, 8'h17};
        6:       entry = {8'h02, 8'h79};
        7:       entry = {8'h03, 8'h79};
        8:       entry = {8'h04, 8'h12};
        9:       entry = {8'h05, 8'h00};
        default: entry = '0;
      endcase
    end
  end

endmodule

// File: rtl/i2c_config_sequencer.sv
// Walks the register table, handing one write at a time to an I2C master,
// retrying NACKed or timed-out transfers and reporting done or fail.
module i2c_config_sequencer
  import i2c_cfg_pkg::*;
#(
  parameter int         NUM_WRITES     = DEF_NUM_WRITES,
  parameter logic [6:0] SLAVE_ADDR     = DEF_SLAVE_ADDR,
  parameter int         MAX_RETRIES    = DEF_MAX_RETRIES,
  parameter int         GAP_CYCLES     = DEF_GAP_CYCLES,
  parameter int         TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       fail,
  output logic [7:0] fail_index,
  output logic [6:0] slav_addr,
  output logic       read_not_write,
  output logic [7:0] reg_addr,
  output logic [7:0] write_data,
  output logic       write_valid,
  input  logic       write_ready,
  input  logic       error
);

  localparam int IDX_W   = cnt_width(NUM_WRITES);
  localparam int RETRY_W = cnt_width(MAX_RETRIES);
  localparam int TMR_MAX = (GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES;
  localparam int TMR_W   = cnt_width(TMR_MAX);

  localparam logic [IDX_W-1:0]   LAST_IDX     = IDX_W'(NUM_WRITES - 1);
  localparam logic [IDX_W-1:0]   IDX_SAT      = IDX_W'(NUM_WRITES);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);
  localparam logic [TMR_W-1:0]   TMR_SAT      = TMR_W'(TMR_MAX);
  localparam logic [TMR_W-1:0]   TIMEOUT_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0]   GAP_LAST     = TMR_W'(GAP_CYCLES - 1);

  seq_state_t         state;
  seq_state_t         state_next;
  logic [IDX_W-1:0]   index;
  logic [RETRY_W-1:0] retry;
  logic [TMR_W-1:0]   timer;
  logic [7:0]         fail_idx_q;
  cfg_entry_t         cur_entry;

  logic in_wait;
  logic timed_out;
  logic xfer_end;
  logic xfer_err;
  logic last_entry;
  logic can_retry;
  logic gap_end;
  logic start_ok;

  config_rom #(
    .NUM_WRITES (NUM_WRITES),
    .IDX_W      (IDX_W)
  ) u_rom (
    .index (index),
    .entry (cur_entry)
  );

  // A transfer ends when the master goes idle again or the wait budget runs
  // out; a timeout is folded into the error path so it gets retried.
  assign in_wait    = (state == WAIT_BUSY) || (state == WAIT_DONE);
  assign timed_out  = in_wait && (timer >= TIMEOUT_LAST);
  assign xfer_end   = timed_out || ((state == WAIT_DONE) && write_ready);
  assign xfer_err   = timed_out || error;
  assign last_entry = (index >= LAST_IDX);
  assign can_retry  = (retry < RETRY_LIMIT);
  assign gap_end    = (state == GAP) && (timer >= GAP_LAST);
  assign start_ok   = start && ((state == IDLE) || (state == DONE) || (state == FAIL));

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state decision.
  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE, FAIL: if (start) state_next = ISSUE;
      ISSUE:            if (write_ready) state_next = WAIT_BUSY;
      WAIT_BUSY, WAIT_DONE: begin
        if (xfer_end) begin
          if (!xfer_err)      state_next = last_entry ? DONE : GAP;
          else if (can_retry) state_next = GAP;
          else                state_next = FAIL;
        end else if ((state == WAIT_BUSY) && !write_ready) begin
          state_next = WAIT_DONE;
        end
      end
      GAP:              if (gap_end) state_next = ISSUE;
      default:          state_next = IDLE;
    endcase
  end

  // Index, retry, shared gap/timeout timer and the latched failing index.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      index      <= '0;
      retry      <= '0;
      timer      <= '0;
      fail_idx_q <= '0;
    end else if (start_ok) begin
      index      <= '0;
      retry      <= '0;
      timer      <= '0;
      fail_idx_q <= '0;
    end else begin
      case (state)
        ISSUE: timer <= '0;
        WAIT_BUSY, WAIT_DONE: begin
          if (xfer_end) begin
            timer <= '0;
            if (!xfer_err) begin
              if (!last_entry) begin
                if (index != IDX_SAT) index <= index + 1'b1;
                retry <= '0;
              end
            end else if (can_retry) begin
              retry <= retry + 1'b1;
            end else begin
              fail_idx_q <= 8'(index);
            end
          end else if (timer != TMR_SAT) begin
            timer <= timer + 1'b1;
          end
        end
        GAP: if (!gap_end && (timer != TMR_SAT)) timer <= timer + 1'b1;
        default: ;
      endcase
    end
  end

  // Status and handshake outputs decoded from state alone.
  always_comb begin
    busy        = 1'b0;
    done        = 1'b0;
    fail        = 1'b0;
    write_valid = 1'b0;
    case (state)
      ISSUE: begin
        busy        = 1'b1;
        write_valid = 1'b1;
      end
      WAIT_BUSY, WAIT_DONE, GAP: busy = 1'b1;
      DONE:    done = 1'b1;
      FAIL:    fail = 1'b1;
      default: ;
    endcase
  end

  assign fail_index     = fail_idx_q;
  assign slav_addr      = SLAVE_ADDR;
  assign read_not_write = 1'b0;
  assign reg_addr       = cur_entry.reg_addr;
  assign write_data     = cur_entry.data;

endmodule

// File: tb/tb_i2c_config_sequencer.sv
// Self-checking bench: behavioural I2C master plus a transaction-level model
// of which writes the sequencer must issue and how the sequence must end.
module tb_i2c_config_sequencer;

  localparam int NW          = 3;
  localparam int MAX_RETRIES = 3;
  localparam int GAP_CYCLES  = 4;
  localparam int XFER_LEN    = 31;
  localparam int STALL_LEN   = 100;
  localparam int ALWAYS      = 99;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       busy, done, fail;
  logic [7:0] fail_index;
  logic [6:0] slav_addr;
  logic       read_not_write;
  logic [7:0] reg_addr, write_data;
  logic       write_valid;
  logic       write_ready = 1'b1;
  logic       error = 1'b0;

  i2c_config_sequencer #(
    .NUM_WRITES     (NW),
    .SLAVE_ADDR     (7'h1A),
    .MAX_RETRIES    (MAX_RETRIES),
    .GAP_CYCLES     (GAP_CYCLES),
    .TIMEOUT_CYCLES (64)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .busy           (busy),
    .done           (done),
    .fail           (fail),
    .fail_index     (fail_index),
    .slav_addr      (slav_addr),
    .read_not_write (read_not_write),
    .reg_addr       (reg_addr),
    .write_data     (write_data),
    .write_valid    (write_valid),
    .write_ready    (write_ready),
    .error          (error)
  );

  always #5 clk = ~clk;

  // Reference table the sequencer must walk.
  logic [7:0] tb_reg[NW] = '{8'h0F, 8'h06, 8'h07};
  logic [7:0] tb_dat[NW] = '{8'h00, 8'h10, 8'h42};

  // Per-entry failure plans: the first N attempts of an entry NACK or stall.
  int nack_plan[NW]     = '{0, 0, 0};
  int stall_plan[NW]    = '{0, 0, 0};
  int plan_base[NW]     = '{0, 0, 0};
  int attempts_seen[NW] = '{0, 0, 0};

  int   m_cnt = 0;
  int   m_e;
  int   m_n;
  logic m_nack = 1'b0;

  function automatic int entry_of(input logic [7:0] ra);
    for (int i = 0; i < NW; i++) if (tb_reg[i] == ra) return i;
    return 0;
  endfunction

  // Behavioural I2C master: ready only while idle, 31-cycle transfers (or a
  // long stall), NACK flag shown in the first idle cycle and then cleared.
  always @(posedge clk) begin
    if (m_cnt > 0) begin
      if (m_cnt == 1) begin
        write_ready <= 1'b1;
        error       <= m_nack;
      end
      m_cnt <= m_cnt - 1;
    end else begin
      if (error) error <= 1'b0;
      if (write_ready && write_valid) begin
        m_e = entry_of(reg_addr);
        m_n = attempts_seen[m_e] - plan_base[m_e] + 1;
        attempts_seen[m_e] <= attempts_seen[m_e] + 1;
        write_ready <= 1'b0;
        m_nack      <= (m_n <= nack_plan[m_e]);
        m_cnt       <= (m_n <= stall_plan[m_e]) ? STALL_LEN : XFER_LEN;
      end
    end
  end

  // Expected transaction list and outcome.
  logic [15:0] exp_list[32];
  int          exp_len;
  logic        exp_done, exp_fail;
  logic [7:0]  exp_fail_idx;

  int checks = 0;
  int errors = 0;
  int hs_total = 0;
  int hs_base = 0;

  logic        prev_valid = 1'b0;
  logic        prev_hs = 1'b0;
  logic        prev_ready = 1'b1;
  logic [15:0] prev_word = '0;
  logic        gap_active = 1'b0;
  int          gap_cnt = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Each entry is written until an attempt succeeds; an entry whose attempts
  // all fail after MAX_RETRIES retries ends the sequence.
  task automatic buildModel();
    exp_len      = 0;
    exp_fail     = 1'b0;
    exp_fail_idx = 8'd0;
    for (int e = 0; e < NW && !exp_fail; e++) begin
      for (int a = 1; a <= MAX_RETRIES + 1; a++) begin
        exp_list[exp_len] = {tb_reg[e], tb_dat[e]};
        exp_len++;
        if (a > nack_plan[e] && a > stall_plan[e]) break;
        if (a == MAX_RETRIES + 1) begin
          exp_fail     = 1'b1;
          exp_fail_idx = 8'(e);
        end
      end
    end
    exp_done = !exp_fail;
  endtask

  // One clock of the compare process: invariants and handshake scoreboard.
  task automatic tick();
    @(negedge clk);
    checkOutput("done_fail_exclusive", {31'd0, done & fail}, 32'd0);
    checkOutput("slave_addr", {25'd0, slav_addr}, 32'h1A);
    checkOutput("read_not_write", {31'd0, read_not_write}, 32'd0);
    if (!busy) checkOutput("valid_when_idle", {31'd0, write_valid}, 32'd0);
    if (prev_valid && !prev_hs && write_valid && rst_n)
      checkOutput("stable_while_valid", {16'd0, reg_addr, write_data}, {16'd0, prev_word});
    if (write_valid && write_ready && rst_n) begin
      if (hs_total - hs_base < exp_len)
        checkOutput("handshake_entry", {16'd0, reg_addr, write_data}, {16'd0, exp_list[hs_total - hs_base]});
      else
        checkOutput("extra_handshake", {16'd0, reg_addr, write_data}, 32'hFFFF_FFFF);
      hs_total++;
    end
    // The sequencer needs one cycle to see the master idle, then the gap.
    if (!rst_n || !busy) begin
      gap_active = 1'b0;
    end else if (gap_active) begin
      gap_cnt++;
      if (write_valid) begin
        checkOutput("gap_length", gap_cnt, GAP_CYCLES + 1);
        gap_active = 1'b0;
      end
    end else if (write_ready && !prev_ready && !write_valid) begin
      gap_active = 1'b1;
      gap_cnt    = 0;
    end
    prev_hs    = write_valid && write_ready;
    prev_valid = write_valid;
    prev_word  = {reg_addr, write_data};
    prev_ready = write_ready;
  endtask

  // Load failure plans, rebuild the model and pulse start.
  task automatic applyStimulus(input int nack_e, input int nack_n, input int stall_e, input int stall_n);
    for (int i = 0; i < NW; i++) begin
      plan_base[i]  = attempts_seen[i];
      nack_plan[i]  = (i == nack_e) ? nack_n : 0;
      stall_plan[i] = (i == stall_e) ? stall_n : 0;
    end
    buildModel();
    hs_base = hs_total;
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("start_latency_valid", {31'd0, write_valid}, 32'd1);
    checkOutput("start_clears_fail", {31'd0, fail}, 32'd0);
    checkOutput("start_clears_fail_index", {24'd0, fail_index}, 32'd0);
    checkOutput("start_clears_done", {31'd0, done}, 32'd0);
  endtask

  task automatic waitEnd(input int budget);
    int n;
    n = 0;
    while (!(done || fail) && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) checkOutput("sequence_end_timeout", {31'd0, done | fail}, 32'd1);
  endtask

  task automatic waitMasterIdle();
    int n;
    n = 0;
    while (!(write_ready && !error && m_cnt == 0) && n < 400) begin
      tick();
      n++;
    end
    if (n >= 400) checkOutput("master_idle_timeout", {31'd0, write_ready}, 32'd1);
  endtask

  task automatic checkFinal(input string tag, input int lit_hs);
    checkOutput({tag, "_done"}, {31'd0, done}, {31'd0, exp_done});
    checkOutput({tag, "_fail"}, {31'd0, fail}, {31'd0, exp_fail});
    checkOutput({tag, "_fail_index"}, {24'd0, fail_index}, {24'd0, exp_fail_idx});
    checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd0);
    checkOutput({tag, "_hs_count"}, hs_total - hs_base, exp_len);
    checkOutput({tag, "_hs_literal"}, hs_total - hs_base, lit_hs);
  endtask

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    // Reset state and no automatic start afterwards.
    repeat (3) tick();
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_done", {31'd0, done}, 32'd0);
    checkOutput("reset_fail", {31'd0, fail}, 32'd0);
    checkOutput("reset_valid", {31'd0, write_valid}, 32'd0);
    checkOutput("reset_fail_index", {24'd0, fail_index}, 32'd0);
    rst_n = 1'b1;
    hs_base = hs_total;
    repeat (10) tick();
    checkOutput("no_auto_restart_busy", {31'd0, busy}, 32'd0);
    checkOutput("no_auto_restart_hs", hs_total - hs_base, 32'd0);

    $display("[TB] nominal sequence");
    applyStimulus(-1, 0, -1, 0);
    waitEnd(3000);
    checkFinal("nominal", 3);
    checkOutput("nominal_done_literal", {31'd0, done}, 32'd1);

    $display("[TB] replay from DONE with start pulsed while busy");
    applyStimulus(-1, 0, -1, 0);
    repeat (40) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    waitEnd(3000);
    checkFinal("replay", 3);

    $display("[TB] single NACK on entry 1");
    applyStimulus(1, 1, -1, 0);
    waitEnd(3000);
    checkFinal("nack_once", 4);

    $display("[TB] entry 2 always NACKs");
    applyStimulus(2, ALWAYS, -1, 0);
    waitEnd(3000);
    checkFinal("nack_always", 6);
    checkOutput("nack_always_index_literal", {24'd0, fail_index}, 32'd2);
    waitMasterIdle();

    $display("[TB] master stalls on entry 1");
    applyStimulus(-1, 0, 1, ALWAYS);
    waitEnd(3000);
    checkFinal("stall", 5);
    checkOutput("stall_index_literal", {24'd0, fail_index}, 32'd1);
    waitMasterIdle();

    $display("[TB] reset in the middle of entry 1");
    applyStimulus(-1, 0, -1, 0);
    n = 0;
    while ((hs_total - hs_base) < 2 && n < 500) begin
      tick();
      n++;
    end
    if (n >= 500) checkOutput("reach_entry1_timeout", hs_total - hs_base, 32'd2);
    repeat (10) tick();
    rst_n = 1'b0;
    tick();
    checkOutput("midreset_busy", {31'd0, busy}, 32'd0);
    checkOutput("midreset_done", {31'd0, done}, 32'd0);
    checkOutput("midreset_fail", {31'd0, fail}, 32'd0);
    checkOutput("midreset_valid", {31'd0, write_valid}, 32'd0);
    checkOutput("midreset_fail_index", {24'd0, fail_index}, 32'd0);
    rst_n = 1'b1;
    repeat (5) tick();
    checkOutput("post_reset_idle", {31'd0, busy}, 32'd0);
    waitMasterIdle();
    applyStimulus(-1, 0, -1, 0);
    waitEnd(3000);
    checkFinal("after_reset", 3);

    repeat (5) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
